ram_wr_burst: RTL and testbench

- Parametrised burst writer that streams valid-qualified data words into a native BRAM port.
- Each burst is programmed with a base byte address and a word count; the writer auto-increments the address by one word per accepted beat and wraps inside a fixed byte window.
- Provides flow control, completion and abort, plus sticky error reporting.
- Sits between the NPU input stream / AXI slave data path and the weight/activation BRAMs.

---
 rtl/ram_wr_burst_if.sv | 25 ++
 rtl/ram_wr_burst.sv | 148 ++++++++++++++
 tb/tb_ram_wr_burst.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_wr_burst_if.sv
// rtl/ram_wr_burst_if.sv - valid/ready write-data stream into the burst writer
//
// Purpose: carries the data beats from the upstream source into ram_wr_burst.
// Signals:
//   i_data        write data word
//   i_data_valid  beat valid (source -> writer)
//   o_data_ready  writer accepts a beat this cycle (writer -> source)
//   i_data_strb   per-byte write strobe, only when RAM_WR_BURST_STRB_EN is defined
// Modports: master = data source, slave = burst writer.
interface ram_wr_burst_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    i_data_valid;
  logic                    o_data_ready;
`ifdef RAM_WR_BURST_STRB_EN
  logic [DATA_WIDTH/8-1:0] i_data_strb;

  modport master (output i_data, output i_data_valid, output i_data_strb, input o_data_ready);
  modport slave  (input i_data, input i_data_valid, input i_data_strb, output o_data_ready);
`else
  modport master (output i_data, output i_data_valid, input o_data_ready);
  modport slave  (input i_data, input i_data_valid, output o_data_ready);
`endif
endinterface

// File: rtl/ram_wr_burst.sv
// rtl/ram_wr_burst.sv - burst writer streaming data beats into a native BRAM port
//
// Purpose: each burst is programmed with a base byte address and a word count.
// Accepted beats are written at base + offset, where the offset advances by one
// word per beat and wraps inside a WINDOW_BYTES window (the base never wraps).
// Optional feature macro: RAM_WR_BURST_STRB_EN adds per-byte strobes on s_data.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start, i_base_addr,
//   i_len                 burst start request, sampled only in IDLE
//   i_abort               terminates an active burst without o_done
//   s_data                valid/ready data stream (slave side)
//   o_busy, o_done        in RUN / one-cycle normal completion pulse
//   o_count               words written in the current or last burst
//   o_err_overrun         sticky: valid data seen outside RUN
//   o_rst_ram, o_en_ram,
//   o_wr_ram, o_ram_addr,
//   o_ram_data            native BRAM port
module ram_wr_burst #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int WINDOW_BYTES = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [LEN_WIDTH-1:0]    i_len,
  input  logic                    i_abort,
  ram_wr_burst_if.slave           s_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [LEN_WIDTH-1:0]    o_count,
  output logic                    o_err_overrun,
  output logic                    o_rst_ram,
  output logic                    o_en_ram,
  output logic [DATA_WIDTH/8-1:0] o_wr_ram,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(WINDOW_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  err_q, err_d;

  logic                  ready;
  logic                  beat;

  // Ready drops combinationally on abort or reset so nothing is written in
  // the cycle that terminates the burst.
  assign ready = (state_q == RUN) && !i_abort && !i_reset;
  assign beat  = s_data.i_data_valid && ready;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    off_d   = off_q;
    len_d   = len_q;
    count_d = count_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          // Word-align the base; the low byte-lane bits are dropped.
          base_d  = i_base_addr & ~ADDR_WIDTH'(BYTES - 1);
          len_d   = i_len;
          off_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = (i_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (beat) begin
          // The offset width equals log2(WINDOW_BYTES), so the add wraps
          // inside the window by itself.
          off_d   = off_q + OFF_W'(BYTES);
          count_d = count_q + LEN_WIDTH'(1);
          if (count_q == len_q - LEN_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Valid data with nowhere to go; takes priority over the start clear.
    if (s_data.i_data_valid && (state_q != RUN)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      off_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      len_q   <= len_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign s_data.o_data_ready = ready;
  assign o_busy              = (state_q == RUN);
  assign o_done              = (state_q == DONE);
  assign o_count             = count_q;
  assign o_err_overrun       = err_q;

  assign o_rst_ram  = i_reset;
  assign o_en_ram   = beat;
  assign o_ram_addr = base_q + ADDR_WIDTH'(off_q);
  assign o_ram_data = s_data.i_data;
`ifdef RAM_WR_BURST_STRB_EN
  assign o_wr_ram   = s_data.i_data_strb & {BYTES{beat}};
`else
  assign o_wr_ram   = {BYTES{beat}};
`endif

endmodule

// File: tb/tb_ram_wr_burst.sv
// tb/tb_ram_wr_burst.sv - directed self-checking bench for ram_wr_burst
module tb_ram_wr_burst;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic [3:0]  strb = 4'hF;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance A: default 4096-byte window. Instance B: 16-byte window.
  ram_wr_burst_if #(.DATA_WIDTH(32)) bus_a ();
  ram_wr_burst_if #(.DATA_WIDTH(32)) bus_b ();
  assign bus_a.i_data       = data;
  assign bus_a.i_data_valid = valid;
  assign bus_b.i_data       = data;
  assign bus_b.i_data_valid = valid;
`ifdef RAM_WR_BURST_STRB_EN
  assign bus_a.i_data_strb  = strb;
  assign bus_b.i_data_strb  = strb;
`endif

  logic        a_busy, a_done, a_err, a_rst, a_en;
  logic [15:0] a_count;
  logic [3:0]  a_wr;
  logic [31:0] a_addr, a_wdata;
  logic        b_busy, b_done, b_err, b_rst, b_en;
  logic [15:0] b_count;
  logic [3:0]  b_wr;
  logic [31:0] b_addr, b_wdata;

  ram_wr_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .WINDOW_BYTES(4096)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base), .i_len(len),
    .i_abort(abort), .s_data(bus_a), .o_busy(a_busy), .o_done(a_done), .o_count(a_count),
    .o_err_overrun(a_err), .o_rst_ram(a_rst), .o_en_ram(a_en), .o_wr_ram(a_wr),
    .o_ram_addr(a_addr), .o_ram_data(a_wdata)
  );

  ram_wr_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .WINDOW_BYTES(16)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base), .i_len(len),
    .i_abort(abort), .s_data(bus_b), .o_busy(b_busy), .o_done(b_done), .o_count(b_count),
    .o_err_overrun(b_err), .o_rst_ram(b_rst), .o_en_ram(b_en), .o_wr_ram(b_wr),
    .o_ram_addr(b_addr), .o_ram_data(b_wdata)
  );

  // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [31:0] b, input logic [15:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_rst !== 1'b1) begin n_err++; $display("FAIL reset_rst_ram got=%b exp=1", a_rst); end
    n_cmp++; if (bus_a.o_data_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", bus_a.o_data_ready); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({a_busy, a_done, a_err, a_en, a_rst} !== 5'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=00000", {a_busy, a_done, a_err, a_en, a_rst}); end
    n_cmp++; if (a_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    n_cmp++; if (a_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", a_addr); end
    next_cycle();
  endtask

  task automatic test_basic();
    start_burst(32'h100, 16'd4);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = 32'hA0 + i;
      @(negedge clk);
      n_cmp++; if (a_en !== 1'b1 || a_wr !== 4'hF) begin n_err++; $display("FAIL basic_en[%0d] got=%b/%h exp=1/f", i, a_en, a_wr); end
      n_cmp++; if (a_addr !== 32'h100 + 4 * i) begin n_err++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, a_addr, 32'h100 + 4 * i); end
      n_cmp++; if (a_wdata !== 32'hA0 + i) begin n_err++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, a_wdata, 32'hA0 + i); end
      n_cmp++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin n_err++; $display("FAIL basic_busy[%0d] got=%b%b exp=10", i, a_busy, a_done); end
      next_cycle();
    end
    valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin n_err++; $display("FAIL basic_done got=%b%b exp=10", a_done, a_busy); end
    n_cmp++; if (a_count !== 16'd4) begin n_err++; $display("FAIL basic_count got=%0d exp=4", a_count); end
    n_cmp++; if (bus_a.o_data_ready !== 1'b0) begin n_err++; $display("FAIL basic_done_ready got=%b exp=0", bus_a.o_data_ready); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b0 || a_count !== 16'd4 || a_err !== 1'b0) begin n_err++; $display("FAIL basic_after got=%b/%0d/%b exp=0/4/0", a_done, a_count, a_err); end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h200, 32'h204};
    start_burst(32'h200, 16'd6);
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      data  = 32'h1000 + i;
      @(negedge clk);
      n_cmp++; if (b_en !== 1'b1 || b_addr !== exp_addr[i]) begin n_err++; $display("FAIL wrap_addr[%0d] got=%b/%h exp=1/%h", i, b_en, b_addr, exp_addr[i]); end
      next_cycle();
    end
    valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_done !== 1'b1 || b_count !== 16'd6) begin n_err++; $display("FAIL wrap_done got=%b/%0d exp=1/6", b_done, b_count); end
    next_cycle();
  endtask

  task automatic test_gapped();
    int writes = 0;
    int k = 0;
    start_burst(32'h40, 16'd3);
    for (int c = 0; c < 5; c++) begin
      valid = (c % 2 == 0);
      data  = 32'h5000 + c;
      @(negedge clk);
      n_cmp++; if (a_addr !== 32'h40 + 4 * k || a_en !== valid) begin n_err++; $display("FAIL gap_cycle[%0d] got=%b/%h exp=%b/%h", c, a_en, a_addr, valid, 32'h40 + 4 * k); end
      if (a_en === 1'b1) writes++;
      if (valid) k++;
      next_cycle();
    end
    valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (writes !== 3) begin n_err++; $display("FAIL gap_writes got=%0d exp=3", writes); end
    n_cmp++; if (a_done !== 1'b1 || a_count !== 16'd3) begin n_err++; $display("FAIL gap_done got=%b/%0d exp=1/3", a_done, a_count); end
    next_cycle();
  endtask

  task automatic test_zero_len();
    start_burst(32'h80, 16'd0);
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_en !== 1'b0) begin n_err++; $display("FAIL zero_done got=%b%b%b exp=100", a_done, a_busy, a_en); end
    n_cmp++; if (a_count !== 16'd0) begin n_err++; $display("FAIL zero_count got=%0d exp=0", a_count); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b0 || a_en !== 1'b0) begin n_err++; $display("FAIL zero_after got=%b%b exp=00", a_done, a_en); end
    next_cycle();
  endtask

  task automatic test_abort();
    start_burst(32'h300, 16'd8);
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      data  = 32'h77 + i;
      next_cycle();
    end
    abort = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_a.o_data_ready !== 1'b0 || a_en !== 1'b0) begin n_err++; $display("FAIL abort_cycle got=%b%b exp=00", bus_a.o_data_ready, a_en); end
    next_cycle();
    abort = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_err++; $display("FAIL abort_idle got=%b%b exp=00", a_busy, a_done); end
    n_cmp++; if (a_count !== 16'd2) begin n_err++; $display("FAIL abort_count got=%0d exp=2", a_count); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b0 || a_err !== 1'b0) begin n_err++; $display("FAIL abort_after got=%b%b exp=00", a_done, a_err); end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    start_burst(32'h300, 16'd8);
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      data  = 32'h88 + i;
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_a.o_data_ready !== 1'b0 || a_en !== 1'b0 || a_rst !== 1'b1) begin n_err++; $display("FAIL rstmid_cycle got=%b%b%b exp=001", bus_a.o_data_ready, a_en, a_rst); end
    next_cycle();
    reset = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_count !== 16'd0) begin n_err++; $display("FAIL rstmid_idle got=%b%b/%0d exp=00/0", a_busy, a_done, a_count); end
    next_cycle();
  endtask

  task automatic test_overrun_restart();
    valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_err !== 1'b0 || a_en !== 1'b0) begin n_err++; $display("FAIL ovr_pre got=%b%b exp=00", a_err, a_en); end
    next_cycle();
    valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_err !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", a_err); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_err !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", a_err); end
    start_burst(32'h103, 16'd2);
    valid = 1'b1;
    data  = 32'hBEEF;
    @(negedge clk);
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", a_err); end
    n_cmp++; if (a_addr !== 32'h100 || a_en !== 1'b1) begin n_err++; $display("FAIL misalign_addr got=%b/%h exp=1/100", a_en, a_addr); end
    next_cycle();
    start = 1'b1;
    base  = 32'h900;
    len   = 16'd5;
    @(negedge clk);
    n_cmp++; if (a_addr !== 32'h104 || a_en !== 1'b1) begin n_err++; $display("FAIL run_start_ignored got=%b/%h exp=1/104", a_en, a_addr); end
    next_cycle();
    start = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b1 || a_count !== 16'd2) begin n_err++; $display("FAIL restart_done got=%b/%0d exp=1/2", a_done, a_count); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0 || a_count !== 16'd2) begin n_err++; $display("FAIL restart_idle got=%b/%0d exp=0/2", a_busy, a_count); end
    next_cycle();
  endtask

`ifdef RAM_WR_BURST_STRB_EN
  task automatic test_strobe();
    logic [3:0] s [3];
    s = '{4'hF, 4'h3, 4'h0};
    start_burst(32'h400, 16'd3);
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      strb  = s[i];
      @(negedge clk);
      n_cmp++; if (a_wr !== s[i] || a_en !== 1'b1 || a_addr !== 32'h400 + 4 * i) begin n_err++; $display("FAIL strb[%0d] got=%h/%b/%h exp=%h/1/%h", i, a_wr, a_en, a_addr, s[i], 32'h400 + 4 * i); end
      next_cycle();
    end
    valid = 1'b0;
    strb  = 4'hF;
    @(negedge clk);
    n_cmp++; if (a_done !== 1'b1 || a_count !== 16'd3) begin n_err++; $display("FAIL strb_done got=%b/%0d exp=1/3", a_done, a_count); end
    next_cycle();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_gapped();
    test_zero_len();
    test_abort();
    test_reset_mid_burst();
    test_overrun_restart();
`ifdef RAM_WR_BURST_STRB_EN
    test_strobe();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
